// File: rtl/serial_borrow_dec_pkg.sv
// ---------------------------------------------------------------------------
// serial_borrow_dec_pkg
// Shared constants for the serial borrow decrementer: default operand and
// chunk widths, FSM state encodings, and helpers that size the chunk index
// and the chunk counter from WIDTH/SIZE.
// Ports: none (package).
// ---------------------------------------------------------------------------
package serial_borrow_dec_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SIZE  = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Counter must hold the full chunk count, hence the extra bit.
    function automatic int cnt_width(input int width, input int size);
        return $clog2(width / size) + 1;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int width, input int size);
        return ((width / size) > 1) ? $clog2(width / size) : 1;
    endfunction

endpackage

// File: rtl/serial_borrow_dec_if.sv
// ---------------------------------------------------------------------------
// serial_borrow_dec_if
// Operand/result handshake bundle for serial_borrow_dec.
//   in_valid/in_ready : operand offer and acceptance
//   A, bin            : operand and borrow-in
//   out_valid/out_ready : result held / result taken
//   D, bout, nchunk   : result, final borrow, number of chunks processed
// Modports: master (producer/consumer side), slave (the decrementer).
// ---------------------------------------------------------------------------
interface serial_borrow_dec_if
    import serial_borrow_dec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SIZE  = DEF_SIZE
) ();

    localparam int CW = cnt_width(WIDTH, SIZE);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             bout;
    logic [CW-1:0]    nchunk;

    modport master (
        output in_valid, A, bin, out_ready,
        input  in_ready, out_valid, D, bout, nchunk
    );

    modport slave (
        input  in_valid, A, bin, out_ready,
        output in_ready, out_valid, D, bout, nchunk
    );

endinterface

// File: rtl/serial_borrow_dec_dec_chunk.sv
// ---------------------------------------------------------------------------
// dec_chunk
// Combinational SIZE-bit decrement stage built as a ripple borrow chain.
//   a    : chunk value
//   bin  : borrow into the chunk (1 = subtract one)
//   diff : a - bin mod 2^SIZE
//   bout : borrow out (set only when bin=1 and a==0)
// ---------------------------------------------------------------------------
module dec_chunk #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] a,
    input  logic            bin,
    output logic [SIZE-1:0] diff,
    output logic            bout
);

    logic b;

    // A bit flips while the borrow is live; the borrow survives only past zeros.
    always_comb begin
        diff = '0;
        b    = bin;
        for (int i = 0; i < SIZE; i++) begin
            diff[i] = a[i] ^ b;
            b       = b & ~a[i];
        end
        bout = b;
    end

endmodule

// File: rtl/serial_borrow_dec.sv
// ---------------------------------------------------------------------------
// serial_borrow_dec
// Decrements a WIDTH-bit operand by its borrow-in, one SIZE-bit chunk per
// cycle, stopping as soon as the borrow dies out.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : serial_borrow_dec_if.slave (operand in, result out)
// ---------------------------------------------------------------------------
module serial_borrow_dec
    import serial_borrow_dec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SIZE  = DEF_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    serial_borrow_dec_if.slave bus
);

    localparam int NCH = WIDTH / SIZE;
    localparam int IW  = idx_width(WIDTH, SIZE);
    localparam int CW  = cnt_width(WIDTH, SIZE);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic             borrow;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;

    logic [SIZE-1:0]  cur_chunk;
    logic [SIZE-1:0]  next_chunk;
    logic             chunk_borrow;
    logic             last_idx;

    assign cur_chunk = work[idx*SIZE +: SIZE];
    assign last_idx  = (idx == IW'(NCH - 1));

    dec_chunk #(.SIZE(SIZE)) u_chunk (
        .a    (cur_chunk),
        .bin  (borrow),
        .diff (next_chunk),
        .bout (chunk_borrow)
    );

    // Only the selected chunk is rewritten; chunks above the point where the
    // borrow dies keep their original value, which is what makes early exit
    // correct.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            work   <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        work   <= bus.A;
                        borrow <= bus.bin;
                        idx    <= '0;
                        cnt    <= '0;
                        state  <= bus.bin ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    work[idx*SIZE +: SIZE] <= next_chunk;
                    borrow                 <= chunk_borrow;
                    cnt                    <= cnt + CW'(1);
                    idx                    <= idx + IW'(1);
                    if (!chunk_borrow || last_idx) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Results come straight from the working registers; they only move in
    // RUN, so they are stable for the whole of DONE.
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.D         = work;
    assign bus.bout      = borrow;
    assign bus.nchunk    = cnt;

endmodule

// File: tb/tb_serial_borrow_dec.sv
// ---------------------------------------------------------------------------
// tb_serial_borrow_dec
// Self-checking bench for serial_borrow_dec (WIDTH=32, SIZE=4): directed
// corner cases, a mid-RUN reset abort, and randomized operands with random
// output stalls compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_serial_borrow_dec;
    import serial_borrow_dec_pkg::*;

    localparam int WIDTH = 32;
    localparam int SIZE  = 4;
    localparam int NCH   = WIDTH / SIZE;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_borrow_dec_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

    serial_borrow_dec #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Chunks visited: every trailing all-zero chunk passes the borrow on,
    // plus the chunk that absorbs it, never more than the operand holds.
    function automatic int modelChunks(input logic [31:0] a, input logic b);
        int tz = 0;
        if (!b) return 0;
        while (tz < NCH && ((a >> (SIZE * tz)) & 32'hF) == 32'h0) tz++;
        return (tz + 1 > NCH) ? NCH : tz + 1;
    endfunction

    // Offer an operand and return just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] a, input logic b);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.bin      = b;
        checkOutput("in_ready_idle", {63'b0, bus.in_ready}, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Wait for the result, check it, hold it for 'stall' cycles, release it.
    task automatic finishOp(input logic [31:0] a, input logic b, input int stall);
        logic [31:0] exp_d;
        logic        exp_b;
        int          exp_n;
        int          edges;
        exp_d = a - {31'b0, b};
        exp_b = b && (a == 32'h0);
        exp_n = modelChunks(a, b);
        edges = 0;
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.A         = $urandom;
        bus.bin       = 1'($urandom_range(0, 1));
        bus.out_ready = 1'b0;
        while (bus.out_valid !== 1'b1 && edges < 2 * NCH) begin
            @(posedge clk); #1;
            edges++;
        end
        if (bus.out_valid !== 1'b1) begin
            checkOutput("out_valid_timeout", {63'b0, bus.out_valid}, 64'd1);
            bus.in_valid = 1'b0;
            rst = 1'b1; #2; rst = 1'b0;
            return;
        end
        // bin=0 results are already held right after the accepting edge.
        checkOutput("latency", 64'(edges), 64'(b ? exp_n : 0));
        checkOutput("D", {32'b0, bus.D}, {32'b0, exp_d});
        checkOutput("bout", {63'b0, bus.bout}, {63'b0, exp_b});
        checkOutput("nchunk", {60'b0, bus.nchunk}, 64'(exp_n));
        checkOutput("in_ready_busy", {63'b0, bus.in_ready}, 64'd0);
        repeat (stall) begin
            @(posedge clk); #1;
            checkOutput("hold_D", {32'b0, bus.D}, {32'b0, exp_d});
            checkOutput("hold_nchunk", {60'b0, bus.nchunk}, 64'(exp_n));
            checkOutput("hold_valid", {63'b0, bus.out_valid}, 64'd1);
            checkOutput("stall_in_ready", {63'b0, bus.in_ready}, 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput("valid_drop", {63'b0, bus.out_valid}, 64'd0);
        checkOutput("in_ready_back", {63'b0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic        b;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state, before any clock edge.
        #3;
        checkOutput("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
        checkOutput("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        checkOutput("rst_D", {32'b0, bus.D}, 64'd0);
        checkOutput("rst_bout", {63'b0, bus.bout}, 64'd0);
        checkOutput("rst_nchunk", {60'b0, bus.nchunk}, 64'd0);

        // First accept on the first edge after release; A=0x10 needs 2 chunks.
        bus.in_valid = 1'b1;
        bus.A        = 32'h0000_0010;
        bus.bin      = 1'b1;
        #9 rst = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput("first_accept", {63'b0, bus.in_ready}, 64'd0);
        finishOp(32'h0000_0010, 1'b1, 0);

        applyStimulus(32'h0000_0000, 1'b1);
        finishOp(32'h0000_0000, 1'b1, 1);

        applyStimulus(32'h1234_5678, 1'b0);
        finishOp(32'h1234_5678, 1'b0, 0);

        applyStimulus(32'h8000_0000, 1'b1);
        finishOp(32'h8000_0000, 1'b1, 5);

        // Reset during the 4th RUN cycle of A=0 aborts without a result.
        applyStimulus(32'h0000_0000, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", {63'b0, bus.out_valid}, 64'd0);
        checkOutput("abort_D", {32'b0, bus.D}, 64'd0);
        checkOutput("abort_nchunk", {60'b0, bus.nchunk}, 64'd0);
        checkOutput("abort_in_ready", {63'b0, bus.in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h0000_0001, 1'b1);
        finishOp(32'h0000_0001, 1'b1, 0);

        // Random operands, biased toward trailing zero chunks.
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            a = a << (SIZE * $urandom_range(0, NCH));
            b = 1'($urandom_range(0, 1));
            applyStimulus(a, b);
            finishOp(a, b, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
